// File: rtl/framebuffer_swap_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : framebuffer_swap_ctrl
// Description : Double-buffer manager for the LED panel frame store. Owns
//               memory port B. The frame writer reaches the back bank through
//               port B. On commit, the banks swap at the display driver's
//               safe_flip pulse. The new front bank can then be copied into
//               the new back bank, so the writer can make incremental updates.
// Revision    : 1.0 - initial release
// ============================================================================
module framebuffer_swap_ctrl #(
    parameter int ADDR_WIDTH   = 8,
    parameter int DATA_WIDTH   = 24,
    parameter bit COPY_ON_FLIP = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  safe_flip,
    output logic                  front_sel,
    output logic                  wr_ready,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_commit,
    output logic                  flipped,
    output logic                  busy,
    output logic [ADDR_WIDTH:0]   pb_addr,
    output logic                  pb_we,
    output logic [DATA_WIDTH-1:0] pb_wdata,
    input  logic [DATA_WIDTH-1:0] pb_rdata
);

    typedef enum logic [1:0] {
        ST_OPEN    = 2'd0,
        ST_PENDING = 2'd1,
        ST_COPY_RD = 2'd2,
        ST_COPY_WR = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic                  r_front_sel;
    logic                  r_flipped;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic                  w_cnt_last;
    logic                  w_wr_ready;
    logic [ADDR_WIDTH:0]   w_pb_addr;
    logic                  w_pb_we;
    logic [DATA_WIDTH-1:0] w_pb_wdata;

    assign w_cnt_last = &r_cnt;

    // State, bank select, flip pulse and copy counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_OPEN;
            r_front_sel <= 1'b0;
            r_flipped   <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_state   <= w_next_state;
            r_flipped <= 1'b0;
            if (r_state == ST_PENDING && safe_flip) begin
                r_front_sel <= ~r_front_sel;
                r_flipped   <= 1'b1;
            end
            // The counter wraps to zero after the last word, ready for the next copy
            if (r_state == ST_COPY_WR) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Next-state logic and port B multiplexing
    always_comb begin
        w_next_state = r_state;
        w_wr_ready   = 1'b0;
        w_pb_addr    = '0;
        w_pb_we      = 1'b0;
        w_pb_wdata   = '0;
        case (r_state)
            ST_OPEN: begin
                // The writer drives port B directly into the back bank
                w_wr_ready = 1'b1;
                w_pb_addr  = {~r_front_sel, wr_addr};
                w_pb_we    = wr_en;
                w_pb_wdata = wr_data;
                if (wr_commit) begin
                    w_next_state = ST_PENDING;
                end
            end
            ST_PENDING: begin
                if (safe_flip) begin
                    if (COPY_ON_FLIP) begin
                        w_next_state = ST_COPY_RD;
                    end else begin
                        w_next_state = ST_OPEN;
                    end
                end
            end
            ST_COPY_RD: begin
                w_pb_addr    = {r_front_sel, r_cnt};
                w_next_state = ST_COPY_WR;
            end
            ST_COPY_WR: begin
                // Read data for word n arrives one cycle after the COPY_RD address
                w_pb_addr  = {~r_front_sel, r_cnt};
                w_pb_we    = 1'b1;
                w_pb_wdata = pb_rdata;
                if (w_cnt_last) begin
                    w_next_state = ST_OPEN;
                end else begin
                    w_next_state = ST_COPY_RD;
                end
            end
            default: begin
                w_next_state = ST_OPEN;
            end
        endcase
    end

    // While reset is held, present the idle values even if a copy was running
    always_comb begin
        if (rst) begin
            wr_ready = 1'b1;
            busy     = 1'b0;
            pb_addr  = '0;
            pb_we    = 1'b0;
            pb_wdata = '0;
        end else begin
            wr_ready = w_wr_ready;
            busy     = (r_state != ST_OPEN);
            pb_addr  = w_pb_addr;
            pb_we    = w_pb_we;
            pb_wdata = w_pb_wdata;
        end
    end

    assign front_sel = r_front_sel;
    assign flipped   = r_flipped;

endmodule
`default_nettype wire

// File: tb/tb_framebuffer_swap_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_framebuffer_swap_ctrl
// Description : Directed self-checking bench for framebuffer_swap_ctrl, with
//               a behavioural dual-bank memory on port B.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_framebuffer_swap_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        safe_flip, wr_en, wr_commit;
    logic [7:0]  wr_addr;
    logic [23:0] wr_data;
    logic        front_sel, wr_ready, flipped, busy, pb_we;
    logic [8:0]  pb_addr;
    logic [23:0] pb_wdata;
    logic [23:0] pb_rdata;

    logic        safe_flip_b, wr_commit_b;
    logic        front_sel_b, wr_ready_b, flipped_b, busy_b, pb_we_b;
    logic [8:0]  pb_addr_b;
    logic [23:0] pb_wdata_b;
    logic [23:0] pb_rdata_b = '0;

    logic [23:0] mem [0:511];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    framebuffer_swap_ctrl #(.ADDR_WIDTH(8), .DATA_WIDTH(24), .COPY_ON_FLIP(1'b1)) u_dut (
        .clk(clk), .rst(rst), .safe_flip(safe_flip), .front_sel(front_sel),
        .wr_ready(wr_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_commit(wr_commit), .flipped(flipped), .busy(busy), .pb_addr(pb_addr),
        .pb_we(pb_we), .pb_wdata(pb_wdata), .pb_rdata(pb_rdata)
    );

    framebuffer_swap_ctrl #(.ADDR_WIDTH(8), .DATA_WIDTH(24), .COPY_ON_FLIP(1'b0)) u_dut_nocopy (
        .clk(clk), .rst(rst), .safe_flip(safe_flip_b), .front_sel(front_sel_b),
        .wr_ready(wr_ready_b), .wr_en(1'b0), .wr_addr(8'h00), .wr_data(24'h0),
        .wr_commit(wr_commit_b), .flipped(flipped_b), .busy(busy_b), .pb_addr(pb_addr_b),
        .pb_we(pb_we_b), .pb_wdata(pb_wdata_b), .pb_rdata(pb_rdata_b)
    );

    // Port B memory: synchronous write, one-cycle read latency
    always @(posedge clk) begin
        if (pb_we) mem[pb_addr] <= pb_wdata;
        pb_rdata <= mem[pb_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; safe_flip = 1'b0; wr_en = 1'b0; wr_commit = 1'b0;
        wr_addr = 8'h00; wr_data = 24'h0; safe_flip_b = 1'b0; wr_commit_b = 1'b0;
        repeat (3) tick();
        settle();
        chk("rst_front_sel", {31'd0, front_sel}, 32'd0);
        chk("rst_wr_ready",  {31'd0, wr_ready},  32'd1);
        chk("rst_busy",      {31'd0, busy},      32'd0);
        chk("rst_flipped",   {31'd0, flipped},   32'd0);
        chk("rst_pb_we",     {31'd0, pb_we},     32'd0);
        chk("rst_pb_addr",   {23'd0, pb_addr},   32'd0);
        chk("rst_pb_wdata",  {8'd0, pb_wdata},   32'd0);

        // Instance without copy: commit, flip, back to OPEN straight away
        tick(); rst = 1'b0; wr_commit_b = 1'b1; settle();
        tick(); wr_commit_b = 1'b0; safe_flip_b = 1'b1; settle();
        chk("nc_busy_pending", {31'd0, busy_b}, 32'd1);
        tick(); safe_flip_b = 1'b0; settle();
        chk("nc_front_sel", {31'd0, front_sel_b}, 32'd1);
        chk("nc_flipped",   {31'd0, flipped_b},   32'd1);
        chk("nc_busy_open", {31'd0, busy_b},      32'd0);
        chk("nc_wr_ready",  {31'd0, wr_ready_b},  32'd1);
        chk("nc_pb_we",     {31'd0, pb_we_b},     32'd0);
        tick(); settle();
        chk("nc_flipped_end", {31'd0, flipped_b}, 32'd0);
        chk("nc_pb_we_end",   {31'd0, pb_we_b},   32'd0);

        // Pass-through write into back bank 1
        tick(); wr_en = 1'b1; wr_addr = 8'h05; wr_data = 24'hFF0000; settle();
        chk("open_pb_addr",   {23'd0, pb_addr},   32'h105);
        chk("open_pb_we",     {31'd0, pb_we},     32'd1);
        chk("open_pb_wdata",  {8'd0, pb_wdata},   32'hFF0000);
        chk("open_front_sel", {31'd0, front_sel}, 32'd0);
        chk("open_wr_ready",  {31'd0, wr_ready},  32'd1);

        // Preload bank 1 word n = n
        for (int n = 0; n < 255; n++) begin
            tick(); wr_addr = 8'(n); wr_data = 24'(n); settle();
        end

        // Last preload write with commit and safe_flip in the same cycle
        tick(); wr_addr = 8'hFF; wr_data = 24'hFF; wr_commit = 1'b1; safe_flip = 1'b1; settle();
        chk("commit_pb_we",   {31'd0, pb_we},   32'd1);
        chk("commit_pb_addr", {23'd0, pb_addr}, 32'h1FF);
        chk("commit_busy",    {31'd0, busy},    32'd0);
        tick(); wr_commit = 1'b0; safe_flip = 1'b0;
        wr_en = 1'b1; wr_addr = 8'h03; wr_data = 24'hABCDEF; settle();
        chk("pend_busy",      {31'd0, busy},      32'd1);
        chk("pend_wr_ready",  {31'd0, wr_ready},  32'd0);
        chk("pend_pb_we",     {31'd0, pb_we},     32'd0);
        chk("pend_front_sel", {31'd0, front_sel}, 32'd0);
        chk("pend_flipped",   {31'd0, flipped},   32'd0);
        repeat (8) tick();
        settle();
        chk("pend_hold_front_sel", {31'd0, front_sel}, 32'd0);
        chk("pend_hold_busy",      {31'd0, busy},      32'd1);
        tick(); safe_flip = 1'b1; wr_en = 1'b0; settle();
        chk("preflip_flipped", {31'd0, flipped}, 32'd0);
        tick(); safe_flip = 1'b0; settle();
        chk("flip_front_sel", {31'd0, front_sel}, 32'd1);
        chk("flip_flipped",   {31'd0, flipped},   32'd1);
        chk("flip_busy",      {31'd0, busy},      32'd1);

        // Copy bank 1 into bank 0, one read/write pair per word
        for (int n = 0; n < 256; n++) begin
            if (n != 0) begin
                tick(); settle();
            end
            chk("copy_rd_addr", {23'd0, pb_addr}, {23'd0, 1'b1, 8'(n)});
            chk("copy_rd_we",   {31'd0, pb_we},   32'd0);
            if (n == 1) chk("copy_flipped_end", {31'd0, flipped}, 32'd0);
            if (n == 128) chk("copy_wr_ready", {31'd0, wr_ready}, 32'd0);
            tick(); safe_flip = (n == 50); settle();
            chk("copy_wr_addr",  {23'd0, pb_addr},  {23'd0, 1'b0, 8'(n)});
            chk("copy_wr_we",    {31'd0, pb_we},    32'd1);
            chk("copy_wr_wdata", {8'd0, pb_wdata},  n);
        end
        tick(); safe_flip = 1'b0; settle();
        chk("copy_done_wr_ready", {31'd0, wr_ready},  32'd1);
        chk("copy_done_busy",     {31'd0, busy},      32'd0);
        chk("copy_done_front",    {31'd0, front_sel}, 32'd1);
        chk("copy_done_pb_addr",  {23'd0, pb_addr},   32'h003);
        chk("mem_bank0_w3",   {8'd0, mem[9'h003]}, 32'd3);
        chk("mem_bank0_w255", {8'd0, mem[9'h0FF]}, 32'd255);
        chk("mem_bank1_w3",   {8'd0, mem[9'h103]}, 32'd3);
        chk("mem_bank0_w5",   {8'd0, mem[9'h005]}, 32'd5);

        // Second flip back to bank 0, bounded wait for its copy
        tick(); wr_commit = 1'b1; settle();
        tick(); wr_commit = 1'b0; safe_flip = 1'b1; settle();
        tick(); safe_flip = 1'b0; settle();
        chk("flip2_front_sel", {31'd0, front_sel}, 32'd0);
        for (int k = 0; k < 600 && busy; k++) begin
            tick(); settle();
        end
        chk("flip2_copy_done", {31'd0, busy}, 32'd0);

        // Third flip to bank 1, then abort the copy at word 100
        tick(); wr_commit = 1'b1; settle();
        tick(); wr_commit = 1'b0; safe_flip = 1'b1; settle();
        tick(); safe_flip = 1'b0; settle();
        chk("flip3_front_sel", {31'd0, front_sel}, 32'd1);
        repeat (200) tick();
        settle();
        chk("abort_rd_addr", {23'd0, pb_addr}, 32'h164);
        tick(); rst = 1'b1; settle();
        tick(); rst = 1'b0; settle();
        chk("abort_busy",      {31'd0, busy},      32'd0);
        chk("abort_front_sel", {31'd0, front_sel}, 32'd0);
        chk("abort_pb_we",     {31'd0, pb_we},     32'd0);
        chk("abort_wr_ready",  {31'd0, wr_ready},  32'd1);
        chk("abort_pb_addr",   {23'd0, pb_addr},   32'h103);
        chk("abort_flipped",   {31'd0, flipped},   32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
